alu_sequencer: RTL and testbench

Multi-cycle execute/write-back stage sitting directly on the register file's read and write ports. Accepts one operation per valid/ready handshake, drives the register-file select lines, samples the destination and source operands from `dbus`/`sbus`, and computes the result; ADD/SUB/logic/MOV take a single cycle, MUL is iterative shift-add and SHL is iterative. It then writes the result back through `dval`/`dwrite` and produces a carry flag for the sequencing logic.

---
 rtl/alu_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Multi-cycle execute/write-back stage on register-file ports.
//            Single-cycle ALU ops, iterative shift-add MUL, iterative SHL.
// Revision : 1.0
// ============================================================================
module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [1:0]       op_dst,
  input  logic [1:0]       op_src,
  input  logic [WIDTH-1:0] dbus,
  input  logic [WIDTH-1:0] sbus,
  output logic [1:0]       dregsel,
  output logic [1:0]       sregsel,
  output logic [WIDTH-1:0] dval,
  output logic             dwrite,
  output logic             done,
  output logic             carry
);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_XOR = 3'b100;
  localparam logic [2:0] c_OP_MOV = 3'b101;
  localparam logic [2:0] c_OP_MUL = 3'b110;
  localparam logic [2:0] c_OP_SHL = 3'b111;
  // Counter must hold both WIDTH (MUL) and a 3-bit shift amount (SHL).
  localparam int c_CW = ($clog2(WIDTH + 1) > 3) ? $clog2(WIDTH + 1) : 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [c_CW-1:0]    r_cnt;
  logic               r_shc;

  logic               r_op_ready;
  logic [1:0]         r_dregsel;
  logic [1:0]         r_sregsel;
  logic [WIDTH-1:0]   r_dval;
  logic               r_dwrite;
  logic               r_done;
  logic               r_carry;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_shl;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [WIDTH-1:0]   w_result;
  logic               w_carry;

  assign w_accept = (r_state == S_IDLE) && op_valid;
  // MUL and SHL finish on the step taken while the counter reads 1 (or 0 for SHL by 0).
  assign w_last   = ((r_op != c_OP_MUL) && (r_op != c_OP_SHL)) || (r_cnt <= c_CW'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_EXEC;
      S_EXEC:  if (w_last) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sum      = {1'b0, r_a} + {1'b0, r_b};
    w_diff     = {1'b0, r_a} - {1'b0, r_b};
    w_acc_step = r_b[0] ? (r_acc + r_mcand) : r_acc;
    w_shl      = (r_cnt != '0) ? {r_a, 1'b0} : {r_shc, r_a};
    w_result   = '0;
    w_carry    = 1'b0;
    case (r_op)
      c_OP_ADD: {w_carry, w_result} = w_sum;
      c_OP_SUB: {w_carry, w_result} = w_diff;
      c_OP_AND: w_result = r_a & r_b;
      c_OP_OR:  w_result = r_a | r_b;
      c_OP_XOR: w_result = r_a ^ r_b;
      c_OP_MOV: w_result = r_b;
      c_OP_MUL: begin
        w_result = w_acc_step[WIDTH-1:0];
        w_carry  = |w_acc_step[2*WIDTH-1:WIDTH];
      end
      c_OP_SHL: {w_carry, w_result} = w_shl;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_cnt      <= '0;
      r_shc      <= 1'b0;
      r_op_ready <= 1'b1;
      r_dregsel  <= '0;
      r_sregsel  <= '0;
      r_dval     <= '0;
      r_dwrite   <= 1'b0;
      r_done     <= 1'b0;
      r_carry    <= 1'b0;
    end else begin
      r_dwrite   <= 1'b0;
      r_done     <= 1'b0;
      r_op_ready <= (w_state_nxt == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= op_code;
            r_dregsel <= op_dst;
            r_sregsel <= op_src;
          end
        end
        S_READ: begin
          r_a     <= dbus;
          r_b     <= sbus;
          r_acc   <= '0;
          r_mcand <= {{WIDTH{1'b0}}, dbus};
          r_shc   <= 1'b0;
          case (r_op)
            c_OP_MUL: r_cnt <= c_CW'(WIDTH);
            c_OP_SHL: r_cnt <= c_CW'(sbus[2:0]);
            default:  r_cnt <= c_CW'(1);
          endcase
        end
        S_EXEC: begin
          if (w_last) begin
            r_dval   <= w_result;
            r_carry  <= w_carry;
            r_dwrite <= 1'b1;
            r_done   <= 1'b1;
          end else begin
            // Only MUL/SHL iterate; each updates its own operands and ignores the rest.
            r_cnt   <= r_cnt - c_CW'(1);
            r_acc   <= w_acc_step;
            r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_a     <= w_shl[WIDTH-1:0];
            r_shc   <= w_shl[WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign op_ready = r_op_ready;
  assign dregsel  = r_dregsel;
  assign sregsel  = r_sregsel;
  assign dval     = r_dval;
  assign dwrite   = r_dwrite;
  assign done     = r_done;
  assign carry    = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Self-checking bench for alu_sequencer with a register-file model.
// Revision : 1.0
// ============================================================================
module tb_alu_sequencer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         op_valid;
  logic         op_ready;
  logic [2:0]   op_code;
  logic [1:0]   op_dst;
  logic [1:0]   op_src;
  logic [W-1:0] dbus;
  logic [W-1:0] sbus;
  logic [1:0]   dregsel;
  logic [1:0]   sregsel;
  logic [W-1:0] dval;
  logic         dwrite;
  logic         done;
  logic         carry;

  logic [W-1:0] rf [4];
  logic [W-1:0] pre_vals [4];
  logic         pre_we;
  int           n_done;
  int           n_dwrite;
  int           n_checks;
  int           n_fail;

  alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_dst(op_dst), .op_src(op_src),
    .dbus(dbus), .sbus(sbus), .dregsel(dregsel), .sregsel(sregsel),
    .dval(dval), .dwrite(dwrite), .done(done), .carry(carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dbus = rf[dregsel];
  assign sbus = rf[sregsel];

  always @(posedge clk) begin
    if (pre_we) begin
      for (int i = 0; i < 4; i++) rf[i] <= pre_vals[i];
    end else if (dwrite) begin
      rf[dregsel] <= dval;
    end
  end

  always @(posedge clk) begin
    if (done) n_done <= n_done + 1;
    if (dwrite) n_dwrite <= n_dwrite + 1;
  end

  // Reference: result, carry and EXEC cycle count straight from the operation rules.
  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int r, output int c, output int k);
    int mask;
    int n;
    mask = (1 << W) - 1;
    c = 0;
    k = 1;
    r = 0;
    case (op)
      0: begin r = a + b; c = (r > mask) ? 1 : 0; end
      1: begin r = a - b; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = b;
      6: begin r = a * b; c = ((r >> W) != 0) ? 1 : 0; k = W; end
      default: begin
        n = b % 8;
        r = a << n;
        c = (n == 0) ? 0 : ((a >> (W - n)) & 1);
        k = (n == 0) ? 1 : n;
      end
    endcase
    r = r & mask;
  endfunction

  task automatic preload(input logic [W-1:0] v0, v1, v2, v3);
    @(negedge clk);
    pre_vals[0] = v0; pre_vals[1] = v1; pre_vals[2] = v2; pre_vals[3] = v3;
    pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issues one op and reports what was observed; cycle 1 is the READ cycle.
  task automatic do_op(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] src,
                       output int lat, output logic [W-1:0] val, output logic c,
                       output bit busy_ok);
    busy_ok = 1'b1;
    @(negedge clk);
    op_valid = 1'b1; op_code = op; op_dst = dst; op_src = src;
    @(negedge clk);
    op_valid = 1'b0; op_code = 3'($urandom); op_dst = 2'($urandom); op_src = 2'($urandom);
    lat = 1;
    if (op_ready) busy_ok = 1'b0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
      if (op_ready) busy_ok = 1'b0;
    end
    val = dval;
    c   = carry;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op_valid = 1'b0; op_code = '0; op_dst = '0; op_src = '0; pre_we = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_op_ready: got %b want 1", op_ready); end
    n_checks++; if (dregsel !== 2'd0) begin n_fail++; $display("FAIL reset_dregsel: got %h want 0", dregsel); end
    n_checks++; if (sregsel !== 2'd0) begin n_fail++; $display("FAIL reset_sregsel: got %h want 0", sregsel); end
    n_checks++; if (dval !== '0) begin n_fail++; $display("FAIL reset_dval: got %h want 0", dval); end
    n_checks++; if (dwrite !== 1'b0) begin n_fail++; $display("FAIL reset_dwrite: got %b want 0", dwrite); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b want 0", carry); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0] op; logic [1:0] dst; logic [1:0] src;
    logic [W-1:0] r0; logic [W-1:0] r1; logic [W-1:0] r2; logic [W-1:0] r3;
    logic [W-1:0] er; logic ec; int el;
  } vec_t;

  task automatic test_directed();
    vec_t vecs [8];
    int lat; logic [W-1:0] v; logic c; bit bok;
    vecs[0] = '{3'd0, 2'd1, 2'd2, 8'h00, 8'hF0, 8'h20, 8'h00, 8'h10, 1'b1, 3};
    vecs[1] = '{3'd1, 2'd1, 2'd2, 8'h00, 8'h05, 8'h07, 8'h00, 8'hFE, 1'b1, 3};
    vecs[2] = '{3'd6, 2'd0, 2'd3, 8'h0C, 8'h00, 8'h00, 8'h0B, 8'h84, 1'b0, 10};
    vecs[3] = '{3'd6, 2'd0, 2'd3, 8'h20, 8'h00, 8'h00, 8'h10, 8'h00, 1'b1, 10};
    vecs[4] = '{3'd7, 2'd2, 2'd1, 8'h00, 8'h03, 8'h81, 8'h00, 8'h08, 1'b0, 5};
    vecs[5] = '{3'd7, 2'd2, 2'd1, 8'h00, 8'h08, 8'h55, 8'h00, 8'h55, 1'b0, 3};
    vecs[6] = '{3'd4, 2'd3, 2'd3, 8'h11, 8'h22, 8'h33, 8'h5A, 8'h00, 1'b0, 3};
    vecs[7] = '{3'd5, 2'd0, 2'd1, 8'hFF, 8'h3C, 8'h00, 8'h00, 8'h3C, 1'b0, 3};
    for (int i = 0; i < 8; i++) begin
      preload(vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].r3);
      do_op(vecs[i].op, vecs[i].dst, vecs[i].src, lat, v, c, bok);
      n_checks++; if (lat != vecs[i].el) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, vecs[i].el); end
      n_checks++; if (v !== vecs[i].er) begin n_fail++; $display("FAIL dir%0d_dval: got %h want %h", i, v, vecs[i].er); end
      n_checks++; if (c !== vecs[i].ec) begin n_fail++; $display("FAIL dir%0d_carry: got %b want %b", i, c, vecs[i].ec); end
      n_checks++; if (rf[vecs[i].dst] !== vecs[i].er) begin n_fail++; $display("FAIL dir%0d_regfile: got %h want %h", i, rf[vecs[i].dst], vecs[i].er); end
      n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL dir%0d_busy_ready: got high want low while busy", i); end
    end
  endtask

  task automatic test_random();
    int a, b, er, ec, ek, lat; logic [W-1:0] v; logic c; bit bok;
    logic [2:0] op; logic [1:0] d, s;
    for (int i = 0; i < 48; i++) begin
      if (i % 8 == 0) preload(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      op = 3'($urandom); d = 2'($urandom); s = 2'($urandom);
      if (i % 6 == 0) op = 3'd6;
      if (i % 6 == 3) op = 3'd7;
      a = int'(rf[d]); b = int'(rf[s]);
      ref_alu(int'(op), a, b, er, ec, ek);
      do_op(op, d, s, lat, v, c, bok);
      n_checks++; if (lat != 2 + ek) begin n_fail++; $display("FAIL rnd%0d_latency op=%0d: got %0d want %0d", i, op, lat, 2 + ek); end
      n_checks++; if (v !== W'(er)) begin n_fail++; $display("FAIL rnd%0d_dval op=%0d a=%h b=%h: got %h want %h", i, op, a, b, v, er); end
      n_checks++; if (c !== 1'(ec)) begin n_fail++; $display("FAIL rnd%0d_carry op=%0d a=%h b=%h: got %b want %0d", i, op, a, b, c, ec); end
      n_checks++; if (rf[d] !== W'(er)) begin n_fail++; $display("FAIL rnd%0d_regfile: got %h want %h", i, rf[d], er); end
      n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_busy_ready: got high want low while busy", i); end
    end
  endtask

  task automatic test_busy_ignore();
    int d0;
    preload(8'h00, 8'h05, 8'h07, 8'h00);
    d0 = n_done;
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd1; op_dst = 2'd1; op_src = 2'd2;
    @(negedge clk);
    op_code = 3'd0; op_dst = 2'd3; op_src = 2'd3;
    @(negedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL busy_ignore_done_count: got %0d want 1", n_done - d0); end
    n_checks++; if (rf[1] !== 8'hFE) begin n_fail++; $display("FAIL busy_ignore_result: got %h want fe", rf[1]); end
    n_checks++; if (rf[3] !== 8'h00) begin n_fail++; $display("FAIL busy_ignore_r3: got %h want 00", rf[3]); end
    n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL carry_hold: got %b want 1", carry); end
    n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL busy_ignore_ready: got %b want 1", op_ready); end
  endtask

  task automatic test_back_to_back();
    int r1, c1, k1, r2, c2, k2, cyc, first_done, d0, lat2;
    logic [W-1:0] v1; logic cc1;
    preload(8'h0C, 8'h0B, 8'($urandom), 8'($urandom));
    ref_alu(6, int'(rf[0]), int'(rf[1]), r1, c1, k1);
    ref_alu(0, int'(rf[2]), int'(rf[3]), r2, c2, k2);
    d0 = n_done;
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd6; op_dst = 2'd0; op_src = 2'd1;
    @(negedge clk);
    op_code = 3'd0; op_dst = 2'd2; op_src = 2'd3;
    cyc = 1; first_done = 0; v1 = '0; cc1 = 1'b0;
    while (!op_ready && cyc < 60) begin
      if (done) begin first_done = cyc; v1 = dval; cc1 = carry; end
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (first_done != 2 + k1) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want %0d", first_done, 2 + k1); end
    n_checks++; if (v1 !== W'(r1)) begin n_fail++; $display("FAIL b2b_first_dval: got %h want %h", v1, r1); end
    n_checks++; if (cc1 !== 1'(c1)) begin n_fail++; $display("FAIL b2b_first_carry: got %b want %0d", cc1, c1); end
    n_checks++; if (cyc != 3 + k1) begin n_fail++; $display("FAIL b2b_ready_return: got cycle %0d want %0d", cyc, 3 + k1); end
    @(negedge clk);
    op_valid = 1'b0;
    n_checks++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept: got ready %b want 0", op_ready); end
    n_checks++; if (dregsel !== 2'd2 || sregsel !== 2'd3) begin n_fail++; $display("FAIL b2b_second_sel: got %0d/%0d want 2/3", dregsel, sregsel); end
    lat2 = 1;
    while (!done && lat2 < 60) begin @(negedge clk); lat2++; end
    n_checks++; if (lat2 != 2 + k2) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want %0d", lat2, 2 + k2); end
    n_checks++; if (dval !== W'(r2)) begin n_fail++; $display("FAIL b2b_second_dval: got %h want %h", dval, r2); end
    repeat (3) @(negedge clk);
    n_checks++; if (n_done - d0 != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", n_done - d0); end
    n_checks++; if (rf[0] !== W'(r1) || rf[2] !== W'(r2)) begin n_fail++; $display("FAIL b2b_regfile: got %h/%h want %h/%h", rf[0], rf[2], r1, r2); end
  endtask

  task automatic test_reset_mid_op();
    int w0, guard;
    logic [W-1:0] snap;
    preload(8'h0C, 8'h0B, 8'h33, 8'h44);
    w0 = n_dwrite;
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd6; op_dst = 2'd0; op_src = 2'd1;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL mid_mul_reset_ready: got %b want 1", op_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++; if (n_dwrite != w0) begin n_fail++; $display("FAIL mid_mul_no_write: got %0d writes want 0", n_dwrite - w0); end
    n_checks++; if (rf[0] !== 8'h0C) begin n_fail++; $display("FAIL mid_mul_regfile: got %h want 0c", rf[0]); end
    n_checks++; if (done !== 1'b0 || op_ready !== 1'b1) begin n_fail++; $display("FAIL mid_mul_idle: got done=%b ready=%b want 0/1", done, op_ready); end
    // Reset while the write strobe is already up must remove it before the next edge.
    snap = rf[2];
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd0; op_dst = 2'd2; op_src = 2'd3;
    @(negedge clk);
    op_valid = 1'b0;
    guard = 0;
    while (!dwrite && guard < 20) begin @(negedge clk); guard++; end
    n_checks++; if (dwrite !== 1'b1) begin n_fail++; $display("FAIL write_reset_setup: got dwrite %b want 1", dwrite); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (dwrite !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL write_reset_async: got dwrite=%b done=%b want 0/0", dwrite, done); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (rf[2] !== snap) begin n_fail++; $display("FAIL write_reset_regfile: got %h want %h", rf[2], snap); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_done = 0; n_dwrite = 0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no completion want finish before 400us");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
